// File: rtl/div128_64.sv
// ----------------------------------------------------------------------------
// div128_64 : sequential unsigned divider, 2*DW-bit dividend / DW-bit divisor.
//
// Inverse companion of the kara128 Karatsuba multiplier: a 128-bit product fed
// back with one operand recovers the other. Restoring division retiring
// STEPS_PER_CYCLE quotient bits per clock.
//
// Optional build macro: DIV_FAST_EN
//   When defined, the CHECK state also resolves yin==0 and bin==1 (upper half
//   zero) directly, with no error and error-path latency. When undefined those
//   operands take the normal iterative path and give identical results.
//
// Ports:
//   clk    in   1      system clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request level; launch on a 0->1 transition only
//   yin    in   2*DW   dividend
//   bin    in   DW     divisor
//   qout   out  DW     quotient
//   rout   out  DW     remainder
//   done   out  1      result valid, held until the next accepted launch
//   busy   out  1      operation in progress
//   err    out  2      bit0 divide-by-zero, bit1 quotient overflow (with done)
// ----------------------------------------------------------------------------
module div128_64 #(
  parameter int unsigned DW              = 64,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] yin,
  input  logic [DW-1:0]   bin,
  output logic [DW-1:0]   qout,
  output logic [DW-1:0]   rout,
  output logic            done,
  output logic            busy,
  output logic [1:0]      err
);

  localparam int unsigned ITERS = DW / STEPS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  // Reject unsupported configurations at elaboration time
  if (!((STEPS_PER_CYCLE == 1) || (STEPS_PER_CYCLE == 2) || (STEPS_PER_CYCLE == 4))
      || ((DW % STEPS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("div128_64: STEPS_PER_CYCLE must be 1, 2 or 4 and divide DW");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [2*DW-1:0]   y_q,     y_d;
  logic [DW-1:0]     b_q,     b_d;
  logic [DW:0]       r_q,     r_d;
  logic [DW-1:0]     qs_q,    qs_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DW-1:0]     qout_q,  qout_d;
  logic [DW-1:0]     rout_q,  rout_d;
  logic [1:0]        err_q,   err_d;
  logic              done_q,  done_d;
  logic              busy_q,  busy_d;

  logic              launch;
  logic [DW:0]       r_step;
  logic [DW-1:0]     q_step;

  // One clock of restoring division: STEPS_PER_CYCLE shift/compare/subtract
  // sub-steps. R stays below the divisor, so DW+1 bits hold the shifted value.
  always_comb begin
    r_step = r_q;
    q_step = qs_q;
    for (int i = 0; i < int'(STEPS_PER_CYCLE); i++) begin
      r_step = {r_step[DW-1:0], q_step[DW-1]};
      q_step = {q_step[DW-2:0], 1'b0};
      if (r_step >= {1'b0, b_q}) begin
        r_step    = r_step - {1'b0, b_q};
        q_step[0] = 1'b1;
      end
    end
  end

  // Only a fresh rising edge in an idle-type state starts an operation
  assign launch = start && !start_q && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    start_d = start;
    y_d     = y_q;
    b_d     = b_q;
    r_d     = r_q;
    qs_d    = qs_q;
    cnt_d   = cnt_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    err_d   = err_q;
    done_d  = done_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          y_d     = yin;
          b_d     = bin;
          done_d  = 1'b0;
          err_d   = 2'b00;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (b_q == '0) begin
          err_d   = 2'b01;
          qout_d  = '1;
          rout_d  = y_q[DW-1:0];
          state_d = DONE;
        end else if (y_q[2*DW-1:DW] >= b_q) begin
          // Quotient would not fit in DW bits
          err_d   = 2'b10;
          qout_d  = '1;
          rout_d  = '1;
          state_d = DONE;
        end
`ifdef DIV_FAST_EN
        else if (y_q == '0) begin
          qout_d  = '0;
          rout_d  = '0;
          state_d = DONE;
        end else if (b_q == DW'(1)) begin
          // Upper half is zero here, otherwise the overflow check fired
          qout_d  = y_q[DW-1:0];
          rout_d  = '0;
          state_d = DONE;
        end
`endif
        else begin
          r_d     = {1'b0, y_q[2*DW-1:DW]};
          qs_d    = y_q[DW-1:0];
          cnt_d   = CNT_W'(ITERS - 1);
          state_d = ITER;
        end
      end

      ITER: begin
        r_d  = r_step;
        qs_d = q_step;
        if (cnt_q == '0) begin
          qout_d  = q_step;
          rout_d  = r_step[DW-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (launch) begin
          y_d     = yin;
          b_d     = bin;
          done_d  = 1'b0;
          err_d   = 2'b00;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      y_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      qs_q    <= '0;
      cnt_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
      err_q   <= 2'b00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      y_q     <= y_d;
      b_q     <= b_d;
      r_q     <= r_d;
      qs_q    <= qs_d;
      cnt_q   <= cnt_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign qout = qout_q;
  assign rout = rout_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_div128_64.sv
// ----------------------------------------------------------------------------
// tb_div128_64 : scoreboard bench for div128_64 at default parameters.
// The driver pushes expected quotient/remainder/err/latency when it launches an
// operation; a monitor pops and compares on every rising edge of done.
// ----------------------------------------------------------------------------
module tb_div128_64;

  localparam int NORM_LAT = 66;
  localparam int ERR_LAT  = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] yin   = '0;
  logic [63:0]  bin   = '0;
  logic [63:0]  qout;
  logic [63:0]  rout;
  logic         done;
  logic         busy;
  logic [1:0]   err;

  div128_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .yin   (yin),
    .bin   (bin),
    .qout  (qout),
    .rout  (rout),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic [1:0]  e;
    int          lat;
    int          launch;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Trivial operands finish early only when the fast path is built in
  function automatic int lat_for(input logic [127:0] y, input logic [63:0] b);
`ifdef DIV_FAST_EN
    if ((b != 0) && (y[127:64] < b) && ((y == 0) || (b == 64'd1))) return ERR_LAT;
`endif
    return NORM_LAT + 0 * int'(y[0] ^ b[0]);
  endfunction

  // Monitor: compare each new result against the oldest expectation
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done && !done_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("%s_qout", e.name), 128'(qout), 128'(e.q));
        check($sformatf("%s_rout", e.name), 128'(rout), 128'(e.r));
        check($sformatf("%s_err",  e.name), 128'(err),  128'(e.e));
        check($sformatf("%s_lat",  e.name), 128'(cyc - e.launch), 128'(e.lat));
      end
    end
    done_prev = done;
  end

  task automatic issue(input logic [127:0] y, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er, input logic [1:0] ee,
                       input int lat, input string name, input bit push, input bit hold);
    exp_t e;
    @(negedge clk);
    yin   = y;
    bin   = b;
    start = 1'b1;
    if (push) begin
      e.q      = eq;
      e.r      = er;
      e.e      = ee;
      e.lat    = lat;
      e.launch = cyc + 1;
      e.name   = name;
      sb.push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
      sb.delete();
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, "_qout"}, 128'(qout), 128'(0));
    check({name, "_rout"}, 128'(rout), 128'(0));
    check({name, "_err"},  128'(err),  128'(0));
    check({name, "_done"}, 128'(done), 128'(0));
    check({name, "_busy"}, 128'(busy), 128'(0));
  endtask

  localparam logic [127:0] Y1 = 128'h0000_0000_0000_0012_3321_0000_0000_0000;

  initial begin
    int lows;
    logic [63:0]  b, up, lo;
    logic [127:0] y;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // Start held high: exactly one operation, done stays up
    issue(Y1, 64'h1111, 64'h0111_0000_0000_0000, 64'h0, 2'b00, NORM_LAT, "held", 1'b1, 1'b1);
    wait_result("held");
    lows = 0;
    repeat (500) begin
      @(negedge clk);
      if (!done) lows++;
    end
    check("held_done_low_cycles", 128'(lows), 128'(0));
    check("held_qout_stable", 128'(qout), 128'(64'h0111_0000_0000_0000));
    check("held_busy", 128'(busy), 128'(0));
    start = 1'b0;

    // Remainder case
    issue(Y1 + 128'd5, 64'h1111, 64'h0111_0000_0000_0000, 64'd5, 2'b00, NORM_LAT, "rem5", 1'b1, 1'b0);
    wait_result("rem5");

    // Divide by zero
    issue(128'hDEAD_BEEF_0000_0001_0123_4567_89AB_CDEF, 64'h0, '1, 64'h0123_4567_89AB_CDEF,
          2'b01, ERR_LAT, "divzero", 1'b1, 1'b0);
    wait_result("divzero");

    // Quotient overflow (upper half equals divisor)
    issue(128'h0000_0000_0000_1111_0000_0000_0000_0000, 64'h1111, '1, '1, 2'b10, ERR_LAT,
          "ovf", 1'b1, 1'b0);
    wait_result("ovf");

    // Trivial operands
    issue(128'h0, 64'd5, 64'h0, 64'h0, 2'b00, lat_for(128'h0, 64'd5), "zero_y", 1'b1, 1'b0);
    wait_result("zero_y");
    y = {64'h0, 64'hABCD_1234_5678_9ABC};
    issue(y, 64'd1, 64'hABCD_1234_5678_9ABC, 64'h0, 2'b00, lat_for(y, 64'd1), "div1", 1'b1, 1'b0);
    wait_result("div1");

    // Reset in the middle of an operation aborts it
    issue(128'd1000, 64'd3, 64'h0, 64'h0, 2'b00, 0, "abort", 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("abort");
    repeat (80) @(negedge clk);
    check("abort_no_result", 128'(done), 128'(0));
    issue(128'd100, 64'd7, 64'd14, 64'd2, 2'b00, NORM_LAT, "after_rst", 1'b1, 1'b0);
    wait_result("after_rst");

    // Rising edge while busy is ignored; operands are latched at launch
    issue(128'h1_0000_0000_0000_0000, 64'd3, 64'h5555_5555_5555_5555, 64'd1, 2'b00, NORM_LAT,
          "busy_ign", 1'b1, 1'b0);
    repeat (19) @(negedge clk);
    yin   = 128'd5;
    bin   = 64'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("busy_ign");
    repeat (80) @(negedge clk);
    check("busy_ign_done_held", 128'(done), 128'(1));
    check("busy_ign_qout_kept", 128'(qout), 128'(64'h5555_5555_5555_5555));
    check("busy_ign_rout_kept", 128'(rout), 128'(1));

    // Sweep of in-range operand pairs against 128-bit reference arithmetic
    for (int i = 0; i < 400; i++) begin
      b = {$urandom(), $urandom()};
      if ((i % 8) == 0) b = 64'($urandom_range(300, 2));
      if (b < 64'd2) b = 64'd2;
      up = {$urandom(), $urandom()} % b;
      lo = {$urandom(), $urandom()};
      y  = {up, lo};
      issue(y, b, 64'(y / {64'h0, b}), 64'(y % {64'h0, b}), 2'b00, lat_for(y, b),
            $sformatf("sweep%0d", i), 1'b1, 1'b0);
      wait_result($sformatf("sweep%0d", i));
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
